// File: rtl/i2c_rx_fifo_gen.sv
// i2c_rx_fifo_gen: parametrised show-ahead RX FIFO between the I2C receive
// engine (write side) and the APB register block (read side). Provides a
// fill level, threshold flag, sticky overflow, flush and an idle-timeout flag.
// Everything runs in the pclk domain.
module i2c_rx_fifo_gen #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4,
    parameter int unsigned TW = 8
) (
    input  logic          pclk,
    input  logic          prst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          not_empty,
    output logic          full,
    output logic [AW:0]   level,
    input  logic [AW:0]   thr_level,
    output logic          thr_hit,
    output logic          ov,
    input  logic          ov_clr,
    input  logic [TW-1:0] to_cyc,
    output logic          to_flag
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [TW-1:0] tcnt;
    logic          wr_ok;
    logic          rd_ok;

    // Status and show-ahead data, derived from the registered pointers only
    always_comb begin
        level     = wptr - rptr;
        full      = (level == DEPTH_V);
        not_empty = (level != '0);
        thr_hit   = (thr_level != '0) && (level >= thr_level);
        rd_data   = mem[rptr[AW-1:0]];
        wr_ok     = wr_en & ~full & ~flush;
        rd_ok     = rd_en & not_empty & ~flush;
    end

    // Storage array: written on accepted writes, intentionally not reset
    always_ff @(posedge pclk) begin
        if (wr_ok) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    // Write/read pointers; flush returns both to zero and overrides traffic
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + (AW+1)'(1);
            if (rd_ok) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Sticky overflow: a dropped write while full sets it, and set beats clear
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            ov <= 1'b0;
        end else if (wr_en && full && !flush) begin
            ov <= 1'b1;
        end else if (ov_clr) begin
            ov <= 1'b0;
        end
    end

    // Idle timeout: count quiet cycles while non-empty; flag after to_cyc of them
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            tcnt    <= '0;
            to_flag <= 1'b0;
        end else begin
            if (flush || wr_ok || rd_ok || !not_empty) begin
                tcnt <= '0;
            end else if ((to_cyc != '0) && !to_flag) begin
                // Counter holds at to_cyc-1 once the flag fires
                if (tcnt == to_cyc - TW'(1)) begin
                    to_flag <= 1'b1;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
            if (flush || rd_ok || !not_empty) begin
                to_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_rx_fifo_gen.sv
// tb_i2c_rx_fifo_gen: directed bench for i2c_rx_fifo_gen. Expected read data
// is queued by the stimulus; a negedge monitor pops and compares on reads.
module tb_i2c_rx_fifo_gen;

    logic       pclk = 1'b0;
    logic       prst_n;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       not_empty;
    logic       full;
    logic [4:0] level;
    logic [4:0] thr_level;
    logic       thr_hit;
    logic       ov;
    logic       ov_clr;
    logic [7:0] to_cyc;
    logic       to_flag;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       rd_exp = 1'b0;

    i2c_rx_fifo_gen #(.DW(8), .AW(4), .TW(8)) dut (
        .pclk(pclk), .prst_n(prst_n), .flush(flush), .wr_en(wr_en),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .not_empty(not_empty), .full(full), .level(level),
        .thr_level(thr_level), .thr_hit(thr_hit), .ov(ov), .ov_clr(ov_clr),
        .to_cyc(to_cyc), .to_flag(to_flag)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every read the stimulus expects to be accepted pops one entry
    always @(negedge pclk) begin
        if (rd_exp) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_scoreboard: got 0x%0h expected <queue empty>", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] v);
        wr_en = 1'b1; wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] v);
        exp_q.push_back(v);
        rd_exp = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rd_exp = 1'b0;
    endtask

    initial begin
        prst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        thr_level = '0; ov_clr = 1'b0; to_cyc = '0;
        repeat (3) tick();
        check("rst_level", 32'(level), 0);
        check("rst_not_empty", 32'(not_empty), 0);
        check("rst_full", 32'(full), 0);
        check("rst_thr_hit", 32'(thr_hit), 0);
        check("rst_ov", 32'(ov), 0);
        check("rst_to_flag", 32'(to_flag), 0);
        prst_n = 1'b1;
        tick();

        // Fill and drain
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i));
            if (i == 14) begin
                check("fill15_full", 32'(full), 0);
                check("fill15_level", 32'(level), 15);
            end
        end
        check("fill_full", 32'(full), 1);
        check("fill_level", 32'(level), 16);
        for (int i = 0; i < 16; i++) do_read(8'(i));
        check("drain_not_empty", 32'(not_empty), 0);
        check("drain_level", 32'(level), 0);

        // Overflow and ov_clr priority
        for (int i = 0; i < 16; i++) do_write(8'(8'h10 + i));
        do_write(8'hAA);
        check("ovf_ov", 32'(ov), 1);
        check("ovf_level", 32'(level), 16);
        ov_clr = 1'b1;
        do_write(8'hBB);
        check("ovclr_set_wins", 32'(ov), 1);
        tick();
        ov_clr = 1'b0;
        check("ovclr_alone", 32'(ov), 0);

        // Full with simultaneous write and read
        wr_en = 1'b1; wr_data = 8'hCC;
        do_read(8'h10);
        wr_en = 1'b0;
        check("full_wr_rd_level", 32'(level), 15);
        check("full_wr_rd_ov", 32'(ov), 1);
        ov_clr = 1'b1; tick(); ov_clr = 1'b0;
        check("ov_cleared", 32'(ov), 0);
        for (int i = 1; i < 16; i++) do_read(8'(8'h10 + i));
        check("ovf_drain_level", 32'(level), 0);

        // Empty with simultaneous write and read: read ignored
        wr_en = 1'b1; wr_data = 8'h5A; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("empty_wr_rd_level", 32'(level), 1);
        check("empty_wr_rd_head", 32'(rd_data), 32'h5A);
        do_read(8'h5A);

        // Wrap-around at a steady level of 3
        for (int i = 0; i < 3; i++) do_write(8'(8'h60 + i));
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h63 + i);
            do_read(8'(8'h60 + i));
            check("wrap_full", 32'(full), 0);
            check("wrap_level", 32'(level), 3);
        end
        wr_en = 1'b0;
        for (int i = 40; i < 43; i++) do_read(8'(8'h60 + i));
        check("wrap_drain_level", 32'(level), 0);

        // Threshold and idle timeout
        thr_level = 5'd4; to_cyc = 8'd10;
        for (int i = 0; i < 3; i++) do_write(8'(8'h90 + i));
        check("thr_below", 32'(thr_hit), 0);
        do_write(8'h93);
        check("thr_at", 32'(thr_hit), 1);
        repeat (9) tick();
        check("to_9_cycles", 32'(to_flag), 0);
        tick();
        check("to_10_cycles", 32'(to_flag), 1);
        do_read(8'h90);
        check("to_clr_by_read", 32'(to_flag), 0);
        check("thr_after_read", 32'(thr_hit), 0);
        thr_level = 5'd3;
        #1 check("thr_equal", 32'(thr_hit), 1);
        thr_level = 5'd17;
        #1 check("thr_above_depth", 32'(thr_hit), 0);
        thr_level = 5'd4;

        // Flush with level 7, ov=1, to_flag=1 and a concurrent write
        for (int i = 0; i < 13; i++) do_write(8'(8'hA0 + i));
        check("pre_flush_full", 32'(full), 1);
        do_write(8'hEE);
        check("pre_flush_ov", 32'(ov), 1);
        for (int i = 1; i < 4; i++) do_read(8'(8'h90 + i));
        for (int i = 0; i < 6; i++) do_read(8'(8'hA0 + i));
        check("pre_flush_level", 32'(level), 7);
        repeat (10) tick();
        check("pre_flush_to", 32'(to_flag), 1);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("flush_level", 32'(level), 0);
        check("flush_not_empty", 32'(not_empty), 0);
        check("flush_to_flag", 32'(to_flag), 0);
        check("flush_ov_kept", 32'(ov), 1);
        do_write(8'h42);
        check("post_flush_head", 32'(rd_data), 32'h42);
        check("post_flush_level", 32'(level), 1);

        // Asynchronous reset mid-operation
        do_write(8'h43);
        #2 prst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 0);
        check("async_rst_ov", 32'(ov), 0);
        check("async_rst_not_empty", 32'(not_empty), 0);
        tick();
        prst_n = 1'b1;
        tick();
        check("after_rst_level", 32'(level), 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
